// File: rtl/alu_serial_frontend_pkg.sv
// Shared types, field layout and frame length for the ALU serial front end.
// Defining ALU_FRAME_PARITY_EN appends an even-parity bit to every frame.
package alu_serial_frontend_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_LUI   = 4'd2,
    ALU_SLL   = 4'd3,
    ALU_SRL   = 4'd4,
    ALU_SRA   = 4'd5,
    ALU_AUIPC = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SLTU  = 4'd8,
    ALU_XOR   = 4'd9,
    ALU_OR    = 4'd10,
    ALU_AND   = 4'd11
  } alu_op_t;

  localparam logic [OP_W-1:0] ALU_OP_MAX = 4'd11;

  localparam int OP_LSB  = 0;
  localparam int OP1_LSB = 4;
  localparam int OP2_LSB = 12;

`ifdef ALU_FRAME_PARITY_EN
  localparam int FRAME_LEN = 21;

  // Whole frame, parity bit included, must XOR to zero.
  function automatic logic frame_parity_ok(input logic [FRAME_LEN-1:0] frame);
    return ~(^frame);
  endfunction
`else
  localparam int FRAME_LEN = 20;
`endif

  localparam int CNT_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    RX   = 2'd0,
    EXEC = 2'd1,
    TX   = 2'd2
  } serfe_state_t;

endpackage

// File: rtl/alu_result_shifter.sv
// Parallel-load, LSB-first result shifter with registered serial output.
module alu_result_shifter
  import alu_serial_frontend_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [RES_W-1:0] i_data,
  output logic             o_bit,
  output logic             o_valid,
  output logic             o_last
);

  logic [RES_W-1:0] r_data;
  logic [3:0]       r_cnt;
  logic             r_bit;
  logic             r_valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_cnt   <= 4'd0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_cnt   <= 4'd0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_shift) begin
      r_bit   <= r_data[0];
      r_valid <= 1'b1;
      r_data  <= {1'b0, r_data[RES_W-1:1]};
      r_cnt   <= r_cnt + 4'd1;
    end else begin
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
    end
  end

  assign o_bit   = r_bit;
  assign o_valid = r_valid;
  // High while the shift for result bit 15 is being issued.
  assign o_last  = (r_cnt == 4'd15);

endmodule

// File: rtl/alu_serial_frontend.sv
// Bit-serial front end: deserialises opcode/operand frames for the ALU and serialises its result.
// Optional build macro: ALU_FRAME_PARITY_EN (adds an even-parity frame bit).
module alu_serial_frontend
  import alu_serial_frontend_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ser_in,
  input  logic              ser_in_valid,
  output alu_op_t           alu_op,
  output logic [DATA_W-1:0] alu_input1,
  output logic [DATA_W-1:0] alu_input2,
  input  logic [RES_W-1:0]  alu_result,
  output logic              ser_out,
  output logic              ser_out_valid,
  output logic              busy,
  output logic              frame_err
);

  serfe_state_t         r_state;
  serfe_state_t         w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_LEN-2:0] r_frame;
  logic [FRAME_LEN-1:0] w_frame_full;
  logic                 w_last_bit;
  logic                 w_frame_ok;
  logic                 w_tx_last;
  alu_op_t              r_op;
  logic [DATA_W-1:0]    r_in1;
  logic [DATA_W-1:0]    r_in2;
  logic                 r_busy;
  logic                 r_frame_err;

  always_comb begin
    w_frame_full = {ser_in, r_frame};
    w_last_bit   = (r_state == RX) && ser_in_valid && (r_cnt == CNT_W'(FRAME_LEN - 1));
`ifdef ALU_FRAME_PARITY_EN
    w_frame_ok   = (w_frame_full[OP_LSB +: OP_W] <= ALU_OP_MAX) && frame_parity_ok(w_frame_full);
`else
    w_frame_ok   = (w_frame_full[OP_LSB +: OP_W] <= ALU_OP_MAX);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= RX;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX: begin
        if (w_last_bit && w_frame_ok) begin
          w_state_nxt = EXEC;
        end else begin
          w_state_nxt = RX;
        end
      end
      EXEC: w_state_nxt = TX;
      TX: begin
        if (w_tx_last) begin
          w_state_nxt = RX;
        end else begin
          w_state_nxt = TX;
        end
      end
      default: w_state_nxt = RX;
    endcase
  end

  // Bits arriving outside RX are dropped and flagged; the running operation is untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_frame     <= '0;
      r_op        <= ALU_ADD;
      r_in1       <= '0;
      r_in2       <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_busy      <= (w_state_nxt != RX);
      if (r_state == RX && ser_in_valid) begin
        r_frame <= w_frame_full[FRAME_LEN-1:1];
        if (w_last_bit) begin
          r_cnt <= '0;
          if (w_frame_ok) begin
            r_op  <= alu_op_t'(w_frame_full[OP_LSB +: OP_W]);
            r_in1 <= w_frame_full[OP1_LSB +: DATA_W];
            r_in2 <= w_frame_full[OP2_LSB +: DATA_W];
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (ser_in_valid) begin
        r_frame_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  alu_result_shifter u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (r_state == EXEC),
    .i_shift (r_state == TX),
    .i_data  (alu_result),
    .o_bit   (ser_out),
    .o_valid (ser_out_valid),
    .o_last  (w_tx_last)
  );

  assign alu_op     = r_op;
  assign alu_input1 = r_in1;
  assign alu_input2 = r_in2;
  assign busy       = r_busy;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_alu_serial_frontend.sv
// Directed bench for alu_serial_frontend with a cycle-level behavioural model and literal checks.
module tb_alu_serial_frontend;

`ifdef ALU_FRAME_PARITY_EN
  localparam int FL = 21;
`else
  localparam int FL = 20;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ser_in;
  logic        ser_in_valid;
  logic [3:0]  alu_op;
  logic [7:0]  alu_input1;
  logic [7:0]  alu_input2;
  logic [15:0] alu_result;
  logic        ser_out;
  logic        ser_out_valid;
  logic        busy;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_serial_frontend dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ser_in        (ser_in),
    .ser_in_valid  (ser_in_valid),
    .alu_op        (alu_op),
    .alu_input1    (alu_input1),
    .alu_input2    (alu_input2),
    .alu_result    (alu_result),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (op)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {b, 8'h00};
      4'd3:    return {8'h00, a} << b[3:0];
      4'd4:    return {8'h00, a >> b[2:0]};
      4'd5:    return sa >>> b[2:0];
      4'd6:    return {8'h00, a} + {b, 8'h00};
      4'd7:    return (sa < sb) ? 16'd1 : 16'd0;
      4'd8:    return (a < b) ? 16'd1 : 16'd0;
      4'd9:    return {8'h00, a ^ b};
      4'd10:   return {8'h00, a | b};
      4'd11:   return {8'h00, a & b};
      default: return 16'h0000;
    endcase
  endfunction

  // The bench plays the combinational ALU.
  assign alu_result = alu_fn(alu_op, alu_input1, alu_input2);

  function automatic logic [FL-1:0] make_frame(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [FL-1:0] f;
    f = '0;
    f[3:0]   = op;
    f[11:4]  = a;
    f[19:12] = b;
`ifdef ALU_FRAME_PARITY_EN
    f[20] = ^f[19:0];
`endif
    return f;
  endfunction

  function automatic bit frame_ok(input logic [FL-1:0] f);
`ifdef ALU_FRAME_PARITY_EN
    return (f[3:0] <= 4'd11) && ((^f) == 1'b0);
`else
    return (f[3:0] <= 4'd11);
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k = edge that accepted the last bit of the latest good frame.
  int            cyc = 0;
  int            m_k = -1000;
  int            m_cnt = 0;
  logic [FL-1:0] m_bits = '0;
  logic [3:0]    m_op = 4'd0;
  logic [7:0]    m_a = 8'd0;
  logic [7:0]    m_b = 8'd0;
  logic [15:0]   m_res = 16'd0;
  logic          m_err = 1'b0;

  always @(posedge clock) begin : model
    int e;
    logic [FL-1:0] fb;
    e = cyc + 1;
    cyc <= e;
    if (!reset_n) begin
      m_k    <= -1000;
      m_cnt  <= 0;
      m_bits <= '0;
      m_op   <= 4'd0;
      m_a    <= 8'd0;
      m_b    <= 8'd0;
      m_err  <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (ser_in_valid) begin
        if (e >= m_k + 1 && e <= m_k + 17) begin
          m_err <= 1'b1;
        end else begin
          fb = m_bits;
          fb[m_cnt] = ser_in;
          if (m_cnt == FL - 1) begin
            m_cnt  <= 0;
            m_bits <= '0;
            if (frame_ok(fb)) begin
              m_k   <= e;
              m_op  <= fb[3:0];
              m_a   <= fb[11:4];
              m_b   <= fb[19:12];
              m_res <= alu_fn(fb[3:0], fb[11:4], fb[19:12]);
            end else begin
              m_err <= 1'b1;
            end
          end else begin
            m_cnt  <= m_cnt + 1;
            m_bits <= fb;
          end
        end
      end
    end
  end

  int          words = 0;
  int          err_cnt = 0;
  int          rx_idx = 0;
  logic [15:0] rx_word = 16'h0;
  logic [15:0] last_word = 16'h0;

  // Single compare process against the model, plus collection of shifted-out words.
  always @(negedge clock) begin : compare
    logic ev;
    logic eb;
    if (cyc >= 1) begin
      ev = (cyc >= m_k + 2) && (cyc <= m_k + 17);
      eb = ev ? m_res[cyc - m_k - 2] : 1'b0;
      check("busy", {15'd0, busy}, {15'd0, (cyc >= m_k) && (cyc <= m_k + 16)});
      check("ser_out_valid", {15'd0, ser_out_valid}, {15'd0, ev});
      check("ser_out", {15'd0, ser_out}, {15'd0, eb});
      check("frame_err", {15'd0, frame_err}, {15'd0, m_err});
      check("alu_op", {12'd0, alu_op}, {12'd0, m_op});
      check("alu_input1", {8'd0, alu_input1}, {8'd0, m_a});
      check("alu_input2", {8'd0, alu_input2}, {8'd0, m_b});
    end
    if (frame_err === 1'b1) err_cnt++;
    if (ser_out_valid === 1'b1) begin
      rx_word[rx_idx] = ser_out;
      rx_idx++;
      if (rx_idx == 16) begin
        last_word = rx_word;
        words++;
        rx_idx = 0;
      end
    end else begin
      rx_idx = 0;
    end
  end

  task automatic send_bits(input logic [FL-1:0] f, input bit gaps);
    for (int i = 0; i < FL; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        repeat (g) begin
          ser_in_valid = 1'b0;
          @(negedge clock);
        end
      end
      ser_in       = f[i];
      ser_in_valid = 1'b1;
      @(negedge clock);
    end
    ser_in_valid = 1'b0;
    ser_in       = 1'b0;
  endtask

  task automatic wait_words(input int target);
    for (int i = 0; i < 80 && words < target; i++) @(negedge clock);
    check("word_timeout", 16'(words), 16'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_op"}, {12'd0, alu_op}, 16'h0);
    check({tag, "_in1"}, {8'd0, alu_input1}, 16'h0);
    check({tag, "_in2"}, {8'd0, alu_input2}, 16'h0);
    check({tag, "_valid"}, {15'd0, ser_out_valid}, 16'h0);
    check({tag, "_ser_out"}, {15'd0, ser_out}, 16'h0);
    check({tag, "_busy"}, {15'd0, busy}, 16'h0);
    check({tag, "_frame_err"}, {15'd0, frame_err}, 16'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w0;
    int e0;
    logic [FL-1:0] f;
    reset_n      = 1'b0;
    ser_in       = 1'b0;
    ser_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // 1: ADD 0x7F + 0x01
    w0 = words;
    send_bits(make_frame(4'd0, 8'h7F, 8'h01), 1'b0);
    check("t1_alu_op", {12'd0, alu_op}, 16'd0);
    check("t1_in1", {8'd0, alu_input1}, 16'h007F);
    check("t1_in2", {8'd0, alu_input2}, 16'h0001);
    wait_words(w0 + 1);
    check("t1_result", last_word, 16'h0080);

    // 2: AND 0xF0 & 0x3C with gaps
    w0 = words;
    e0 = err_cnt;
    send_bits(make_frame(4'd11, 8'hF0, 8'h3C), 1'b1);
    wait_words(w0 + 1);
    check("t2_result", last_word, 16'h0030);
    check("t2_no_err", 16'(err_cnt), 16'(e0));

    // 3: illegal opcode 13 is dropped
    w0 = words;
    e0 = err_cnt;
    send_bits(make_frame(4'd13, 8'h12, 8'h34), 1'b0);
    repeat (20) @(negedge clock);
    check("t3_err_pulses", 16'(err_cnt), 16'(e0 + 1));
    check("t3_no_output", 16'(words), 16'(w0));
    check("t3_alu_op_kept", {12'd0, alu_op}, 16'd11);
    check("t3_in1_kept", {8'd0, alu_input1}, 16'h00F0);
    check("t3_in2_kept", {8'd0, alu_input2}, 16'h003C);

    // 4: SLL 0x81 << 4 with three stray bits during TX
    w0 = words;
    e0 = err_cnt;
    send_bits(make_frame(4'd3, 8'h81, 8'h04), 1'b0);
    repeat (4) @(negedge clock);
    ser_in       = 1'b1;
    ser_in_valid = 1'b1;
    repeat (3) @(negedge clock);
    ser_in_valid = 1'b0;
    ser_in       = 1'b0;
    wait_words(w0 + 1);
    check("t4_err_pulses", 16'(err_cnt), 16'(e0 + 3));
    check("t4_result", last_word, 16'h0810);

    // 5: reset while TX bit 5 is on the wire, then OR 0x0F | 0xA0
    w0 = words;
    send_bits(make_frame(4'd0, 8'h01, 8'h02), 1'b0);
    repeat (7) @(negedge clock);
    check("t5_mid_tx", {15'd0, ser_out_valid}, 16'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_all_zero("t5_reset");
    check("t5_no_word", 16'(words), 16'(w0));
    send_bits(make_frame(4'd10, 8'h0F, 8'hA0), 1'b0);
    wait_words(w0 + 1);
    check("t5_result", last_word, 16'h00AF);

`ifdef ALU_FRAME_PARITY_EN
    // 6: XOR with bad then good parity
    w0 = words;
    e0 = err_cnt;
    f = make_frame(4'd9, 8'hFF, 8'h0F);
    f[20] = ~f[20];
    send_bits(f, 1'b0);
    repeat (20) @(negedge clock);
    check("t6_par_err", 16'(err_cnt), 16'(e0 + 1));
    check("t6_no_output", 16'(words), 16'(w0));
    send_bits(make_frame(4'd9, 8'hFF, 8'h0F), 1'b0);
    wait_words(w0 + 1);
    check("t6_result", last_word, 16'h00F0);
`else
    f = make_frame(4'd9, 8'hFF, 8'h0F);
    w0 = words;
    send_bits(f, 1'b0);
    wait_words(w0 + 1);
    check("t6_xor_result", last_word, 16'h00F0);
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
